// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared pipeline-register types for the 5-stage RV32I core.
package pipe_stage_ctrl_pkg;

  localparam int NUM_STAGE_REGS = 4;
  localparam int VLD_IF_ID  = 0;
  localparam int VLD_ID_EX  = 1;
  localparam int VLD_EX_MEM = 2;
  localparam int VLD_MEM_WB = 3;

  typedef logic [NUM_STAGE_REGS-1:0] stage_valid_t;

  typedef struct packed {
    logic [31:0] Curr_Pc;
    logic [31:0] Curr_Instr;
  } if_id_reg;

  typedef struct packed {
    logic [31:0] Curr_Pc;
    logic [31:0] Rs1_Data;
    logic [31:0] Rs2_Data;
    logic [31:0] Imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  Alu_Op;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        Jump;
    logic        JumpR;
  } id_ex_reg;

  typedef struct packed {
    logic [31:0] Curr_Pc;
    logic [31:0] Alu_Result;
    logic [31:0] Rs2_Data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
  } ex_mem_reg;

  typedef struct packed {
    logic [31:0] Alu_Result;
    logic [31:0] Mem_Data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemToReg;
  } mem_wb_reg;

  // All-zero buffer contents: every control bit off, so no architectural effect.
  localparam if_id_reg  IF_ID_BUBBLE  = '0;
  localparam id_ex_reg  ID_EX_BUBBLE  = '0;
  localparam ex_mem_reg EX_MEM_BUBBLE = '0;
  localparam mem_wb_reg MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_ctrl_load_use_detect.sv
// Load-use hazard detect: load in EX whose rd feeds either source field in ID.
module load_use_detect
  import pipe_stage_ctrl_pkg::*;
(
  input  logic       id_ex_vld,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  output logic       lu
);

  // Both source fields are compared for every opcode; an occasional false stall is harmless.
  always_comb begin
    lu = id_ex_vld & id_ex_mem_read & (id_ex_rd != 5'd0)
         & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Inter-stage buffers, valid bits, stall/bubble/flush control and perf counters.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  if_id_reg         if_id_d,
  input  id_ex_reg         id_ex_d,
  input  ex_mem_reg        ex_mem_d,
  input  mem_wb_reg        mem_wb_d,
  input  logic             br_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output if_id_reg         if_id_q,
  output id_ex_reg         id_ex_q,
  output ex_mem_reg        ex_mem_q,
  output mem_wb_reg        mem_wb_q,
  output stage_valid_t     valid_q,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  if_id_reg     if_id_n;
  id_ex_reg     id_ex_n;
  ex_mem_reg    ex_mem_n;
  mem_wb_reg    mem_wb_n;
  stage_valid_t vld_pipe, vld_n;
  logic         lu;

  assign valid_q = vld_pipe;

  load_use_detect u_lud (
    .id_ex_vld      (vld_pipe[VLD_ID_EX]),
    .id_ex_mem_read (id_ex_q.MemRead),
    .id_ex_rd       (id_ex_q.rd),
    .if_id_rs1      (if_id_q.Curr_Instr[19:15]),
    .if_id_rs2      (if_id_q.Curr_Instr[24:20]),
    .lu             (lu)
  );

  // Next-state select: memory freeze > branch flush > load-use bubble > advance.
  always_comb begin
    if_id_n  = if_id_q;
    id_ex_n  = id_ex_q;
    ex_mem_n = ex_mem_q;
    mem_wb_n = mem_wb_q;
    vld_n    = vld_pipe;
    pc_write = 1'b1;
    if (mem_stall) begin
      pc_write = 1'b0;
    end else if (br_taken) begin
      if_id_n  = IF_ID_BUBBLE;
      id_ex_n  = ID_EX_BUBBLE;
      ex_mem_n = ex_mem_d;
      mem_wb_n = mem_wb_d;
      vld_n    = {vld_pipe[2], vld_pipe[1], 2'b00};
    end else if (lu) begin
      id_ex_n  = ID_EX_BUBBLE;
      ex_mem_n = ex_mem_d;
      mem_wb_n = mem_wb_d;
      vld_n    = {vld_pipe[2], vld_pipe[1], 1'b0, vld_pipe[0]};
      pc_write = 1'b0;
    end else begin
      if_id_n  = if_id_d;
      id_ex_n  = id_ex_d;
      ex_mem_n = ex_mem_d;
      mem_wb_n = mem_wb_d;
      vld_n    = {vld_pipe[2:0], 1'b1};
    end
    // PC must be free to load the reset vector while held in reset.
    if (!reset) pc_write = 1'b1;
  end

  // Buffer and valid registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q  <= IF_ID_BUBBLE;
      id_ex_q  <= ID_EX_BUBBLE;
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
      vld_pipe <= '0;
    end else begin
      if_id_q  <= if_id_n;
      id_ex_q  <= id_ex_n;
      ex_mem_q <= ex_mem_n;
      mem_wb_q <= mem_wb_n;
      vld_pipe <= vld_n;
    end
  end

  // Free-running perf counters, wrapping at 2**CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (vld_pipe[VLD_MEM_WB] && !mem_stall) instret_cnt <= instret_cnt + CNT_W'(1);
      if (mem_stall || (lu && !br_taken))     stall_cnt   <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl with a queue of expected post-edge values.
module tb_pipe_stage_ctrl;
  import pipe_stage_ctrl_pkg::*;

  localparam int S_IFID = 0, S_IDEX = 1, S_IDEXZ = 2, S_EXMEM = 3, S_MEMWB = 4;
  localparam int S_VALID = 5, S_PCW = 6, S_CYC = 7, S_INST = 8, S_STALL = 9, S_W4CYC = 10;

  localparam logic [31:0] I_LW   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_ADDI = 32'h00100393; // addi x7,x0,1
  localparam logic [31:0] I_BEQ  = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_NOP  = 32'h00000013;

  logic clk = 1'b0;
  logic reset;
  if_id_reg if_id_d, if_id_q, w4_if_id_q;
  id_ex_reg id_ex_d, id_ex_q, w4_id_ex_q;
  ex_mem_reg ex_mem_d, ex_mem_q, w4_ex_mem_q;
  mem_wb_reg mem_wb_d, mem_wb_q, w4_mem_wb_q;
  logic br_taken, mem_stall, pc_write, w4_pc_write;
  stage_valid_t valid_q, w4_valid_q;
  logic [31:0] cycle_cnt, instret_cnt, stall_cnt;
  logic [3:0] w4_cycle_cnt, w4_instret_cnt, w4_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .if_id_d(if_id_d), .id_ex_d(id_ex_d), .ex_mem_d(ex_mem_d),
    .mem_wb_d(mem_wb_d), .br_taken(br_taken), .mem_stall(mem_stall), .pc_write(pc_write),
    .if_id_q(if_id_q), .id_ex_q(id_ex_q), .ex_mem_q(ex_mem_q), .mem_wb_q(mem_wb_q),
    .valid_q(valid_q), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
  );

  pipe_stage_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .if_id_d(if_id_d), .id_ex_d(id_ex_d), .ex_mem_d(ex_mem_d),
    .mem_wb_d(mem_wb_d), .br_taken(br_taken), .mem_stall(mem_stall), .pc_write(w4_pc_write),
    .if_id_q(w4_if_id_q), .id_ex_q(w4_id_ex_q), .ex_mem_q(w4_ex_mem_q), .mem_wb_q(w4_mem_wb_q),
    .valid_q(w4_valid_q), .cycle_cnt(w4_cycle_cnt), .instret_cnt(w4_instret_cnt),
    .stall_cnt(w4_stall_cnt)
  );

  typedef struct { int sel; logic [63:0] exp; } sb_t;
  sb_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned e_cyc = 0, e_inst = 0, e_stall = 0, e_cyc4 = 0;
  stage_valid_t ev = '0, ev_nxt = '0;
  if_id_reg  l_if;
  id_ex_reg  l_ex;
  ex_mem_reg l_em;
  mem_wb_reg l_wb;

  function automatic if_id_reg mk_if(input logic [31:0] pc, input logic [31:0] ins);
    mk_if = '{Curr_Pc: pc, Curr_Instr: ins};
  endfunction

  function automatic id_ex_reg mk_ex(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic mr, input logic rw, input logic br);
    mk_ex = '0;
    mk_ex.Curr_Pc = pc; mk_ex.Rs1_Data = pc + 32'd1; mk_ex.Rs2_Data = pc + 32'd2;
    mk_ex.Imm = pc + 32'd3; mk_ex.rs1 = rd + 5'd1; mk_ex.rs2 = rd + 5'd2; mk_ex.rd = rd;
    mk_ex.Alu_Op = 4'h3; mk_ex.MemRead = mr; mk_ex.RegWrite = rw; mk_ex.Branch = br;
  endfunction

  function automatic ex_mem_reg mk_em(input logic [31:0] pc, input logic [31:0] alu);
    mk_em = '0;
    mk_em.Curr_Pc = pc; mk_em.Alu_Result = alu; mk_em.Rs2_Data = ~alu; mk_em.rd = 5'd3;
    mk_em.RegWrite = 1'b1;
  endfunction

  function automatic mem_wb_reg mk_wb(input logic [31:0] alu, input logic [31:0] md);
    mk_wb = '{Alu_Result: alu, Mem_Data: md, rd: 5'd4, RegWrite: 1'b1, MemToReg: 1'b0};
  endfunction

  function automatic logic [63:0] p_idex(input id_ex_reg r);
    p_idex = {r.Curr_Pc, 21'd0, r.rd, r.RegWrite, r.MemRead, r.MemWrite, r.Branch, r.Jump, r.JumpR};
  endfunction

  function automatic string sname(input int sel);
    case (sel)
      S_IFID:  sname = "if_id_q";
      S_IDEX:  sname = "id_ex_q";
      S_IDEXZ: sname = "id_ex_bubble";
      S_EXMEM: sname = "ex_mem_q";
      S_MEMWB: sname = "mem_wb_q";
      S_VALID: sname = "valid_q";
      S_PCW:   sname = "pc_write";
      S_CYC:   sname = "cycle_cnt";
      S_INST:  sname = "instret_cnt";
      S_STALL: sname = "stall_cnt";
      default: sname = "w4_cycle_cnt";
    endcase
  endfunction

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S_IFID:  obs = if_id_q;
      S_IDEX:  obs = p_idex(id_ex_q);
      S_IDEXZ: obs = {63'd0, (id_ex_q == ID_EX_BUBBLE)};
      S_EXMEM: obs = {ex_mem_q.Curr_Pc, ex_mem_q.Alu_Result};
      S_MEMWB: obs = {mem_wb_q.Alu_Result, mem_wb_q.Mem_Data};
      S_VALID: obs = {60'd0, valid_q};
      S_PCW:   obs = {63'd0, pc_write};
      S_CYC:   obs = {32'd0, cycle_cnt};
      S_INST:  obs = {32'd0, instret_cnt};
      S_STALL: obs = {32'd0, stall_cnt};
      default: obs = {60'd0, w4_cycle_cnt};
    endcase
  endfunction

  task automatic chk(input int sel, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", sname(sel), o, e);
    end
  endtask

  task automatic push(input int sel, input logic [63:0] e);
    sb_q.push_back('{sel: sel, exp: e});
  endtask

  task automatic flush_sb();
    sb_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      chk(s.sel, obs(s.sel), s.exp);
    end
  endtask

  task automatic push_cnt();
    push(S_CYC, {32'd0, e_cyc});
    push(S_INST, {32'd0, e_inst});
    push(S_STALL, {32'd0, e_stall});
    push(S_W4CYC, {32'd0, e_cyc4});
  endtask

  task automatic exp_bufs(input if_id_reg a, input id_ex_reg b, input ex_mem_reg c,
                          input mem_wb_reg d, input stage_valid_t v);
    push(S_IFID, a);
    push(S_IDEX, p_idex(b));
    push(S_EXMEM, {c.Curr_Pc, c.Alu_Result});
    push(S_MEMWB, {d.Alu_Result, d.Mem_Data});
    push(S_VALID, {60'd0, v});
    ev_nxt = v;
  endtask

  task automatic drv(input if_id_reg a, input id_ex_reg b, input ex_mem_reg c,
                     input mem_wb_reg d, input logic ms, input logic br, input logic pcw_exp);
    if_id_d = a; id_ex_d = b; ex_mem_d = c; mem_wb_d = d;
    mem_stall = ms; br_taken = br;
    #1;
    chk(S_PCW, {63'd0, pc_write}, {63'd0, pcw_exp});
  endtask

  // lu_exp is the hazard the test writer intends to be present in this cycle.
  task automatic tick(input logic lu_exp);
    if (!mem_stall && ev[VLD_MEM_WB]) e_inst++;
    if (mem_stall || (lu_exp && !br_taken)) e_stall++;
    e_cyc++;
    e_cyc4 = (e_cyc4 + 1) % 16;
    @(posedge clk); #1;
    ev = ev_nxt;
    push_cnt();
    flush_sb();
  endtask

  initial begin
    stage_valid_t fill [4];
    fill[0] = 4'b1001; fill[1] = 4'b0011; fill[2] = 4'b0111; fill[3] = 4'b1111;
    reset = 1'b0; mem_stall = 1'b1; br_taken = 1'b0;
    if_id_d = mk_if(32'h1, I_ADD); id_ex_d = mk_ex(32'h2, 5, 1, 1, 0);
    ex_mem_d = mk_em(32'h3, 32'h4); mem_wb_d = mk_wb(32'h5, 32'h6);
    repeat (2) @(posedge clk);
    #1;
    exp_bufs(IF_ID_BUBBLE, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE, 4'b0000);
    push(S_IDEXZ, 64'd1);
    push(S_PCW, 64'd1);
    push_cnt();
    flush_sb();
    reset = 1'b1;

    // Load-use: lw x5 then dependent add
    drv(mk_if(32'h0, I_LW), mk_ex(32'h100, 0, 0, 0, 0), mk_em(32'h200, 32'h11), mk_wb(32'h22, 32'h33), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b0001); tick(0);
    drv(mk_if(32'h4, I_ADD), mk_ex(32'h0, 5, 1, 1, 0), mk_em(32'h204, 32'h12), mk_wb(32'h23, 32'h34), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b0011); tick(0);
    drv(mk_if(32'h8, I_ADDI), mk_ex(32'h4, 6, 0, 1, 0), mk_em(32'h0, 32'h1000), mk_wb(32'h24, 32'h35), 0, 0, 0);
    exp_bufs(mk_if(32'h4, I_ADD), ID_EX_BUBBLE, ex_mem_d, mem_wb_d, 4'b0101);
    push(S_IDEXZ, 64'd1); tick(1);
    drv(mk_if(32'h8, I_ADDI), mk_ex(32'h4, 6, 0, 1, 0), mk_em(32'h208, 32'h13), mk_wb(32'h1000, 32'h55), 0, 0, 1);
    exp_bufs(if_id_d, mk_ex(32'h4, 6, 0, 1, 0), ex_mem_d, mem_wb_d, 4'b1011); tick(0);
    drv(mk_if(32'hC, I_BEQ), mk_ex(32'h8, 7, 0, 1, 0), mk_em(32'h4, 32'h77), mk_wb(32'h13, 32'h0), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b0111); tick(0);
    drv(mk_if(32'h10, I_NOP), mk_ex(32'hC, 0, 0, 0, 1), mk_em(32'h8, 32'h1), mk_wb(32'h77, 32'h0), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b1111); tick(0);

    // Taken branch: beq resolves in EX
    drv(mk_if(32'h14, I_NOP), mk_ex(32'h10, 0, 0, 0, 0), mk_em(32'hC, 32'hB), mk_wb(32'h1, 32'h0), 0, 1, 1);
    exp_bufs(IF_ID_BUBBLE, ID_EX_BUBBLE, mk_em(32'hC, 32'hB), mem_wb_d, 4'b1100);
    push(S_IDEXZ, 64'd1); tick(0);

    // Branch and load-use in the same cycle: flush wins
    drv(mk_if(32'h40, I_LW), mk_ex(32'h3C, 9, 0, 1, 0), mk_em(32'h300, 32'h1), mk_wb(32'h301, 32'h2), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b1001); tick(0);
    drv(mk_if(32'h44, I_ADD), mk_ex(32'h40, 5, 1, 1, 0), mk_em(32'h302, 32'h3), mk_wb(32'h303, 32'h4), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b0011); tick(0);
    drv(mk_if(32'h48, I_NOP), mk_ex(32'h44, 6, 0, 1, 0), mk_em(32'h304, 32'h5), mk_wb(32'h305, 32'h6), 0, 1, 1);
    exp_bufs(IF_ID_BUBBLE, ID_EX_BUBBLE, ex_mem_d, mem_wb_d, 4'b0100);
    push(S_IDEXZ, 64'd1); tick(1);

    // Refill to four valid stages
    for (int i = 0; i < 4; i++) begin
      drv(mk_if(32'h80 + 32'(4*i), I_NOP), mk_ex(32'h7C + 32'(4*i), 5'(10+i), 0, 1, 0),
          mk_em(32'h400 + 32'(i), 32'(i)), mk_wb(32'h500 + 32'(i), 32'(i)), 0, 0, 1);
      exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, fill[i]); tick(0);
    end
    l_if = if_id_d; l_ex = id_ex_d; l_em = ex_mem_d; l_wb = mem_wb_d;

    // mem_stall for three cycles: everything frozen
    for (int j = 0; j < 3; j++) begin
      drv(mk_if(32'hF00 + 32'(j), I_ADD), mk_ex(32'hF10, 5, 1, 1, 1), mk_em(32'hF20, 32'hF30),
          mk_wb(32'hF40, 32'hF50), 1, j == 1, 0);
      exp_bufs(l_if, l_ex, l_em, l_wb, 4'b1111); tick(0);
    end
    drv(mk_if(32'h90, I_NOP), mk_ex(32'h8C, 14, 0, 1, 0), mk_em(32'h410, 32'h7), mk_wb(32'h510, 32'h8), 0, 0, 1);
    exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, 4'b1111); tick(0);

    // Asynchronous reset between edges with four valid instructions in flight
    mem_stall = 1'b1;
    #3 reset = 1'b0;
    #1;
    e_cyc = 0; e_inst = 0; e_stall = 0; e_cyc4 = 0;
    exp_bufs(IF_ID_BUBBLE, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE, 4'b0000);
    push(S_PCW, 64'd1);
    push_cnt();
    flush_sb();
    ev = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Counter wrap on the CNT_W=4 instance
    for (int k = 1; k <= 17; k++) begin
      drv(mk_if(32'h1000 + 32'(4*k), I_NOP), mk_ex(32'h2000 + 32'(k), 5'(k), 0, 1, 0),
          mk_em(32'h3000, 32'(k)), mk_wb(32'h4000, 32'(k)), 0, 0, 1);
      exp_bufs(if_id_d, id_ex_d, ex_mem_d, mem_wb_d, (k >= 4) ? 4'b1111 : 4'((1 << k) - 1));
      tick(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
